serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencing controller that performs a 4·NIBBLES-bit add or subtract by time-multiplexing one `four_bit_adder` instance over NIBBLES cycles, least-significant nibble first, with a registered carry between nibbles. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades throughput for area in datapaths that need wide arithmetic but own only the 4-bit ripple adder.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (W = 4·NIBBLES); legal range 1..16.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: controller can accept operands.
- `a` input W: operand A.
- `b` input W: operand B.
- `sub` input 1: 0 = A+B, 1 = A−B.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `s` output W: sum/difference.
- `cout` output 1: final carry out. For subtract, 1 = no borrow.
- `ovf` output 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `a`, `b` (b inverted if `sub`) and `sub`.
  - Load the carry register with `sub` (carry-in 1 for subtract).
  - Clear the nibble index; go to RUN.
- RUN: each cycle, feed nibble k of A and B' plus the carry register to the adder.
  - Write the adder sum into `s[4k+3:4k]` and its cout into the carry register; k++.
  - After nibble NIBBLES−1, go to DONE.
- DONE: `out_valid`=1. `s`, `cout` = final carry and `ovf` are held stable.
  - `ovf` = (A[W−1] == B'[W−1]) && (s[W−1] != A[W−1]).
  - On `out_ready`, go to IDLE.
- Port inputs are ignored outside the IDLE accept cycle. Latched operands are not disturbed by input changes.
- No overlap: `in_ready`=0 in RUN and DONE, including the DONE cycle where `out_ready`=1.
- Reset values:
  - State IDLE, `in_ready`=1, `out_valid`=0.
  - `s`=0, `cout`=0, `ovf`=0.
  - Carry register, index and operand registers all 0.
- Reset asserted mid-RUN or in DONE: the operation is abandoned immediately, no result is produced, and the FSM is in IDLE on release.
- `s`, `cout` and `ovf` may change during RUN. Consumers sample them only while `out_valid`=1.

## Timing
- Accept at rising edge T0.
- Nibble k is computed in the cycle after edge T0+k, for k = 0..NIBBLES−1.
- DONE is entered at edge T0+NIBBLES; `out_valid` is high from then.
- Minimum latency from accept to `out_valid`: NIBBLES cycles.
- Best-case throughput: one operation per NIBBLES+2 cycles (accept, NIBBLES RUN cycles, DONE with `out_ready`=1, then back to IDLE).
- `out_valid` stays high indefinitely under backpressure, with all outputs frozen.
- The adder path is combinational within one cycle: a registered nibble index and operand mux feed the adder, and the adder feeds the carry and `s` registers. No combinational path runs from any input port to any output port.

## Structure
- Shared package `adder_pkg`:
  - FSM state encoding constants (IDLE=0, RUN=1, DONE=2, 2 bits).
  - `NIBBLE_W` = 4.
  - Index width function or constant: clog2 of NIBBLES, minimum 1.
- Exactly one sub-module: the existing `four_bit_adder`, instantiated once, with ports `a`, `b`, `cin`, `s`, `cout`.
- Nibble select is an indexed part-select on the latched operands. No per-nibble adder replication.

## Test plan
All scenarios use NIBBLES=4.
- **Add, no carry:** a=0x1234, b=0x4321, sub=0 → after 4 cycles, s=0x5555, cout=0, ovf=0.
- **Full carry ripple across nibbles:** a=0xFFFF, b=0x0001, sub=0 → s=0x0000, cout=1, ovf=0.
- **Subtract with borrow:** a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cout=0, ovf=0.
- **Signed overflow:**
  - a=0x7FFF, b=0x0001, sub=0 → s=0x8000, ovf=1.
  - a=0x8000, b=0x0001, sub=1 → s=0x7FFF, ovf=1.
- **Backpressure and input isolation:**
  - Hold `out_ready`=0 for 10 cycles after DONE → `out_valid`, `s` and `cout` stay constant, and `in_ready` stays 0.
  - Change `a`/`b` during RUN → result unaffected.
  - Release `out_ready` → IDLE on the next cycle, then `in_ready`=1.
- **Reset mid-operation:**
  - Accept a=0x1234, b=0x1111, then pull `rst_n` low two cycles later → `out_valid`=0, `s`=0 and `in_ready`=1 immediately.
  - After release, run a=0x0001, b=0x0001 → s=0x0002.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder controller: FSM encoding, nibble
// width and nibble-index sizing.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// 4-bit adder with carry in/out; the one arithmetic block the controller owns.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_sum;

  assign w_sum = 5'(a) + 5'(b) + 5'(cin);
  assign s     = w_sum[3:0];
  assign cout  = w_sum[4];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide add/subtract built by stepping one four_bit_adder across the operands,
// least-significant nibble first, with valid/ready handshakes on both sides.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                        cout,
  output logic                        ovf
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IW    = idx_width(NIBBLES);
  localparam int unsigned LSB_W = $clog2(W);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_s;
  logic              r_carry;
  logic              r_ovf;
  logic [IW-1:0]     r_idx;
  logic [LSB_W-1:0]  w_lsb;
  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic [NIBBLE_W-1:0] w_sum;
  logic              w_cout;
  logic              w_accept;
  logic              w_last;

  // Handshake outputs decode the state register only, never an input port.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign cout      = r_carry;
  assign ovf       = r_ovf;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_idx == IW'(NIBBLES - 1));
  assign w_lsb    = LSB_W'({r_idx, 2'b00});
  assign w_nib_a  = r_a[w_lsb +: NIBBLE_W];
  assign w_nib_b  = r_b[w_lsb +: NIBBLE_W];

  four_bit_adder u_adder (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1: invert B here, inject the +1 via the carry.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s[w_lsb +: NIBBLE_W] <= w_sum;
      r_carry                <= w_cout;
      r_idx                  <= r_idx + 1'b1;
      if (w_last) begin
        r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_sum[NIBBLE_W-1] != r_a[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed, table-driven bench for serial_adder_ctrl with NIBBLES=4.
module tb_serial_adder_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [9];

  serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge while the DUT is idle.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    sub      = ts;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sub      = 1'($urandom);
  endtask

  // Counts edges after accept until out_valid; scrambles inputs meanwhile.
  task automatic wait_done(output int lat);
    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < 20) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s",         32'(s),         32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(N));
      check($sformatf("v%0d_s", i),    32'(s),    32'(vecs[i].exp_s));
      check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check($sformatf("v%0d_ovf", i),  32'(ovf),  32'(vecs[i].exp_ovf));
      release_result($sformatf("v%0d", i));
    end

    // Backpressure: result frozen and new operands refused while held.
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'(N));
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
      check($sformatf("bp%0d_s", k),         32'(s),         32'h8000);
      check($sformatf("bp%0d_cout", k),      32'(cout),      32'd0);
      check($sformatf("bp%0d_ovf", k),       32'(ovf),       32'd1);
    end
    in_valid = 1'b0;
    release_result("bp");

    // Reset two cycles into an operation abandons it.
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_s",         32'(s),         32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'(N));
    check("post_rst_s",       32'(s),   32'h0002);
    check("post_rst_cout",    32'(cout), 32'd0);
    release_result("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
